// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: FSM encoding, opcode width
// and instruction field offsets derived from the data and register-address widths.
package alu_issue_ctrl_pkg;

    localparam int OP_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IMM  = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Fields pack downward from the MSB: op, rd, rs; bit 0 is the immediate flag.
    function automatic int op_lsb(input int data_w);
        return data_w - OP_W;
    endfunction

    function automatic int rd_lsb(input int data_w, input int reg_aw);
        return data_w - OP_W - reg_aw;
    endfunction

    function automatic int rs_lsb(input int data_w, input int reg_aw);
        return data_w - OP_W - 2 * reg_aw;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Small register file: async clear, one write port, three combinational read ports.
// Reads see the old value until the write edge; no bypass.
module alu_issue_regfile #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] ra0,
    output logic [DATA_W-1:0] rd0,
    input  logic [REG_AW-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd2
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rd0 = regs[ra0];
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of a combinational ALU: decodes a byte
// instruction (optional immediate byte), drives registered operands, writes back result.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_zero,
    output logic              zero_flag,
    output logic              done,
    output logic              busy,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int OP_LSB = op_lsb(DATA_W);
    localparam int RD_LSB = rd_lsb(DATA_W, REG_AW);
    localparam int RS_LSB = rs_lsb(DATA_W, REG_AW);

    state_t            state;
    logic [REG_AW-1:0] rd_q;
    logic [OP_W-1:0]   op_q;

    logic [OP_W-1:0]   f_op;
    logic [REG_AW-1:0] f_rd;
    logic [REG_AW-1:0] f_rs;
    logic              f_imm;
    logic              xfer;
    logic [REG_AW-1:0] ra_a;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic              wb_en;

    assign f_op  = in_data[OP_LSB +: OP_W];
    assign f_rd  = in_data[RD_LSB +: REG_AW];
    assign f_rs  = in_data[RS_LSB +: REG_AW];
    assign f_imm = in_data[0];

    assign in_ready = ena && (state == ST_IDLE || state == ST_IMM);
    assign busy     = (state != ST_IDLE);
    assign xfer     = in_valid && in_ready;
    assign wb_en    = ena && (state == ST_EXEC);

    // While waiting for the immediate, operand A comes from the latched rd.
    assign ra_a = (state == ST_IMM) ? rd_q : f_rd;

    alu_issue_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_en),
        .wa    (rd_q),
        .wd    (alu_r),
        .ra0   (ra_a),
        .rd0   (rd_val),
        .ra1   (f_rs),
        .rd1   (rs_val),
        .ra2   (dbg_sel),
        .rd2   (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_q      <= '0;
            op_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            zero_flag <= 1'b0;
            done      <= 1'b0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        rd_q <= f_rd;
                        if (f_imm) begin
                            op_q  <= f_op;
                            state <= ST_IMM;
                        end else begin
                            alu_a  <= rd_val;
                            alu_b  <= rs_val;
                            alu_op <= f_op;
                            state  <= ST_EXEC;
                        end
                    end
                end
                ST_IMM: begin
                    if (xfer) begin
                        alu_a  <= rd_val;
                        alu_b  <= in_data;
                        alu_op <= op_q;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    zero_flag <= alu_zero;
                    done      <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios with literal expectations plus
// randomized instruction traffic compared every cycle against a transaction-level model.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_r;
    logic       alu_zero;
    logic       zero_flag;
    logic       done;
    logic       busy;
    logic [1:0] dbg_sel = 2'd0;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;
    bit rnd = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return b;
            3'd2: return a - b;
            3'd3: return a & b;
            3'd4: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_r    = alu_fn(alu_a, alu_b, alu_op);
    assign alu_zero = (alu_r == 8'h00);

    alu_issue_ctrl #(.DATA_W(8), .REG_AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r     (alu_r),
        .alu_zero  (alu_zero),
        .zero_flag (zero_flag),
        .done      (done),
        .busy      (busy),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted instruction needs two more enabled edges
    // (writeback, then the completion cycle) before the next one can be taken.
    logic [7:0] m_regs [4];
    logic       m_zero;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [2:0] m_op;
    logic [2:0] m_pop;
    logic [1:0] m_rd;
    logic       m_wait_imm;
    int         m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
            m_zero <= 1'b0; m_a <= 8'h00; m_b <= 8'h00; m_op <= 3'd0;
            m_pop <= 3'd0; m_rd <= 2'd0; m_wait_imm <= 1'b0; m_left <= 0;
        end else if (ena) begin
            if (m_left == 2) begin
                m_regs[m_rd] <= alu_fn(m_a, m_b, m_op);
                m_zero       <= (alu_fn(m_a, m_b, m_op) == 8'h00);
                m_left       <= 1;
            end else if (m_left == 1) begin
                m_left <= 0;
            end else if (in_valid) begin
                if (m_wait_imm) begin
                    m_a <= m_regs[m_rd]; m_b <= in_data; m_op <= m_pop;
                    m_wait_imm <= 1'b0; m_left <= 2;
                end else if (in_data[0]) begin
                    m_wait_imm <= 1'b1; m_pop <= in_data[7:5]; m_rd <= in_data[4:3];
                end else begin
                    m_a <= m_regs[in_data[4:3]]; m_b <= m_regs[in_data[2:1]];
                    m_op <= in_data[7:5]; m_rd <= in_data[4:3]; m_left <= 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", in_ready, ena && m_left == 0);
            chk("busy", busy, m_wait_imm || m_left != 0);
            chk("done", done, m_left == 1);
            chk("zero_flag", zero_flag, m_zero);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_op", alu_op, m_op);
            chk("dbg_data", dbg_data, m_regs[dbg_sel]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            ena = ($urandom_range(0, 3) != 0);
            dbg_sel = 2'($urandom_range(0, 3));
        end
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        bit x;
        in_valid = 1'b1;
        in_data = b;
        for (int i = 0; i < 300; i++) begin
            x = in_ready && ena;
            tick();
            if (x) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_zero", zero_flag, 0);
        chk("rst_alu", {alu_a, alu_b, 5'd0, alu_op}, 0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1 chk("rst_reg", dbg_data, 0);
        end
        dbg_sel = 2'd0;

        // Immediate load reg0 = 5A; done exactly one cycle, two cycles after the transfer
        send(8'h21);
        send(8'h5A);
        @(negedge clk);
        chk("imm_done_c1", done, 0);
        @(negedge clk);
        chk("imm_done_c2", done, 1);
        chk("imm_reg0", dbg_data, 8'h5A);
        chk("imm_zero", zero_flag, 0);
        @(negedge clk);
        chk("imm_done_c3", done, 0);
        chk("imm_ready_c3", in_ready, 1);

        // reg1 = 03, then reg0 = reg0 + reg1
        send(8'h29);
        send(8'h03);
        repeat (2) @(negedge clk);
        send(8'h02);
        @(negedge clk);
        chk("rr_alu_a", alu_a, 8'h5A);
        chk("rr_alu_b", alu_b, 8'h03);
        chk("rr_alu_op", alu_op, 0);
        @(negedge clk);
        chk("rr_reg0", dbg_data, 8'h5D);

        // rd==rs subtract gives zero; following add of 01 clears the flag
        @(negedge clk);
        send(8'h40);
        repeat (2) @(negedge clk);
        chk("sub_reg0", dbg_data, 8'h00);
        chk("sub_zero", zero_flag, 1);
        send(8'h01);
        send(8'h01);
        repeat (2) @(negedge clk);
        chk("add_reg0", dbg_data, 8'h01);
        chk("add_zero", zero_flag, 0);

        // Immediate byte delayed five cycles: controller just waits
        send(8'h21);
        repeat (5) begin
            @(negedge clk);
            chk("stall_busy", busy, 1);
            chk("stall_ready", in_ready, 1);
            chk("stall_reg0", dbg_data, 8'h01);
        end
        send(8'h77);
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("frz_reg0", dbg_data, 8'h01);
            chk("frz_ready", in_ready, 0);
            chk("frz_done", done, 0);
        end
        ena = 1'b1;
        @(negedge clk);
        chk("frz_wb", dbg_data, 8'h77);
        chk("frz_done_on", done, 1);
        ena = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("done_hold", done, 1);
        end
        ena = 1'b1;
        @(negedge clk);
        chk("done_release", done, 0);

        // Reset in EXEC: immediate return to idle, cleared regs, no done pulse
        send(8'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_reg0", dbg_data, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_done", done, 0);
            chk("arst_reg0_after", dbg_data, 0);
        end

        // Randomized traffic with random ena and immediate delays
        rnd = 1'b1;
        for (int n = 0; n < 250; n++) begin
            b = 8'($urandom);
            send(b);
            if (b[0]) begin
                repeat ($urandom_range(0, 3)) tick();
                send(8'($urandom));
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd = 1'b0;
        ena = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
